stack_unit: RTL and testbench
=============================

# stack_unit

Hardware operand stack for the 16-bit stack processor: the datapath pushes results in and pops operands out, with the top two entries always visible combinationally. Where `register` is a single write-then-read cell, `stack_unit` is the read/pop side of the datapath's storage: ALU and branch logic consume `tos`/`nos` directly and issue `pop` when operands are used. It sits between the control unit's push/pop strobes and the ALU operand inputs.

## Interface
- `WIDTH`, 16: data width in bits.
- `DEPTH`, 32: number of stack entries; power of two, at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clk`.
- `push`  in  1: write `w_data` onto the stack this cycle.
- `pop`  in  1: remove the top entry this cycle.
- `w_data`  in  WIDTH: data to push.
- `tos`  out  WIDTH: top of stack, combinational from state; 0 when empty.
- `nos`  out  WIDTH: next on stack, combinational from state; 0 when count < 2.
- `count`  out  log2(DEPTH)+1: number of valid entries, 0..DEPTH.
- `empty`  out  1: count == 0.
- `full`  out  1: count == DEPTH.
- `overflow`  out  1: sticky; set by a rejected push.
- `underflow`  out  1: sticky; set by a rejected pop.

## Operation
- State: storage array `mem[0..DEPTH-1]`, entry counter `count`, and two sticky error bits.
- Reset: count = 0, overflow = 0, underflow = 0. Array contents are not cleared and are don't-care. After reset: tos = 0, nos = 0, empty = 1, full = 0.
- Reset has priority over push and pop in the same cycle.
- push only, not full: mem[count] <= w_data; count <= count+1.
- push only, full: no state change except overflow <= 1.
- pop only, not empty: count <= count-1. The popped entry is not cleared.
- pop only, empty: no state change except underflow <= 1.
- push and pop, count >= 1: replace the top entry: mem[count-1] <= w_data; count unchanged. No error, including when full.
- push and pop, empty: behaves as push only (count becomes 1, tos = w_data). No error.
- Neither asserted: hold.
- Read: tos = mem[count-1] when count >= 1, else 0; nos = mem[count-2] when count >= 2, else 0.
- Sticky flags clear only on reset.

## Timing
- Zero-latency read: tos, nos, count, empty and full reflect state after the most recent rising edge, with no extra cycle.
- Effects of a push or pop become visible on the outputs immediately after the edge that samples it.
- Back-to-back push/pop every cycle is supported with no bubbles.
- Error flags rise on the edge that samples the illegal operation.
- Inputs are sampled only on the rising edge. Glitches between edges have no effect.

## Structure
- Package `stack_pkg`: constants `STACK_WIDTH` = 16 and `STACK_DEPTH` = 32, and a localparam function for the counter width.
- Sub-module `stack_mem`:
  - WIDTH×DEPTH array with one synchronous write port (`we`, `waddr`, `wdata`).
  - Two asynchronous read ports (`raddr0`/`rdata0`, `raddr1`/`rdata1`).
- `stack_unit` holds:
  - the counter and next-state logic,
  - write-address selection (count or count-1),
  - the read-address decode and zero-masking,
  - the flag logic.

## Test plan
- Reset, then idle 2 cycles -> count = 0, empty = 1, tos = 0, nos = 0, overflow = 0, underflow = 0.
- Push 1, 256, 16'hFFFF on consecutive cycles -> after the third edge: count = 3, tos = 16'hFFFF, nos = 256. Then pop twice -> tos = 1, nos = 0, count = 1.
- Push 32 values 0..31 -> full = 1, tos = 31, nos = 30.
  - 33rd push of 16'hAAAA -> count stays 32, tos stays 31, overflow = 1 and stays 1 over 5 further idle cycles.
- From empty, pop -> underflow = 1, count = 0. Then push 7 -> tos = 7, underflow still 1.
- Combined operations:
  - With stack [5, 9] (tos = 9), push and pop with w_data = 42 -> count = 2, tos = 42, nos = 5.
  - From empty, push and pop with w_data = 3 -> count = 1, tos = 3, no flags.
- With count = 4 and overflow = 1, assert reset together with push -> next cycle count = 0, flags = 0, tos = 0. The push is ignored.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the operand stack: default data width, depth and
// the counter-width helper used to size the entry counter.
package stack_pkg;

  localparam int STACK_WIDTH = 16;
  localparam int STACK_DEPTH = 32;

  // The counter must hold 0..depth inclusive, so it needs one bit beyond the address.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port and two asynchronous read ports
// so both top entries are visible in the same cycle.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: entry counter, push/pop next-state logic, sticky error flags
// and zero-masked top/next-on-stack read ports.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int CW = cnt_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [CW-1:0]    cnt_m1, cnt_m2;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             is_empty, is_full;

  assign cnt_m1   = count_q - CW'(1);
  assign cnt_m2   = count_q - CW'(2);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Push+pop on a non-empty stack overwrites the top in place, even when full.
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = count_q[AW-1:0];
    if (push && pop) begin
      we = 1'b1;
      if (is_empty) begin
        count_d = count_q + CW'(1);
      end else begin
        waddr = cnt_m1[AW-1:0];
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        count_d = cnt_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (we && !reset),
    .waddr  (waddr),
    .wdata  (w_data),
    .raddr0 (cnt_m1[AW-1:0]),
    .rdata0 (rdata0),
    .raddr1 (cnt_m2[AW-1:0]),
    .rdata1 (rdata1)
  );

  // Entries beyond the valid count are stale, so mask them to zero.
  assign tos       = (count_q >= CW'(1)) ? rdata0 : '0;
  assign nos       = (count_q >= CW'(2)) ? rdata1 : '0;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit with hand-computed expectations.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] w_data = '0;
  logic [15:0] tos, nos;
  logic [5:0]  count;
  logic        empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  stack_unit dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .w_data    (w_data),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, then settle 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic [15:0] d);
    push = p; pop = q; w_data = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 16'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b expected 0", full); end
    checks++; if (tos !== 16'h0) begin errors++; $display("[TB] FAIL reset_tos got %h expected 0000", tos); end
    checks++; if (nos !== 16'h0) begin errors++; $display("[TB] FAIL reset_nos got %h expected 0000", nos); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_unf got %b expected 0", underflow); end
  endtask

  task automatic test_push_pop();
    do_reset();
    cycle(1'b1, 1'b0, 16'd1);
    checks++; if (tos !== 16'd1) begin errors++; $display("[TB] FAIL pp_tos1 got %h expected 0001", tos); end
    checks++; if (nos !== 16'd0) begin errors++; $display("[TB] FAIL pp_nos1 got %h expected 0000", nos); end
    cycle(1'b1, 1'b0, 16'd256);
    cycle(1'b1, 1'b0, 16'hFFFF);
    checks++; if (count !== 6'd3) begin errors++; $display("[TB] FAIL pp_count3 got %0d expected 3", count); end
    checks++; if (tos !== 16'hFFFF) begin errors++; $display("[TB] FAIL pp_tos3 got %h expected ffff", tos); end
    checks++; if (nos !== 16'd256) begin errors++; $display("[TB] FAIL pp_nos3 got %h expected 0100", nos); end
    cycle(1'b0, 1'b1, 16'h0);
    cycle(1'b0, 1'b1, 16'h0);
    checks++; if (count !== 6'd1) begin errors++; $display("[TB] FAIL pp_count1 got %0d expected 1", count); end
    checks++; if (tos !== 16'd1) begin errors++; $display("[TB] FAIL pp_tos_pop got %h expected 0001", tos); end
    checks++; if (nos !== 16'd0) begin errors++; $display("[TB] FAIL pp_nos_pop got %h expected 0000", nos); end
    cycle(1'b0, 1'b1, 16'h0);
    checks++; if (empty !== 1'b1 || tos !== 16'h0) begin errors++; $display("[TB] FAIL pp_empty got empty=%b tos=%h expected empty=1 tos=0000", empty, tos); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL pp_unf got %b expected 0", underflow); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 16'(i));
      checks++; if (count !== 6'(i + 1)) begin errors++; $display("[TB] FAIL fill_count got %0d expected %0d", count, i + 1); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag got %b expected 1", full); end
    checks++; if (tos !== 16'd31) begin errors++; $display("[TB] FAIL full_tos got %0d expected 31", tos); end
    checks++; if (nos !== 16'd30) begin errors++; $display("[TB] FAIL full_nos got %0d expected 30", nos); end
    cycle(1'b1, 1'b0, 16'hAAAA);
    checks++; if (count !== 6'd32) begin errors++; $display("[TB] FAIL ovf_count got %0d expected 32", count); end
    checks++; if (tos !== 16'd31) begin errors++; $display("[TB] FAIL ovf_tos got %h expected 001f", tos); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", overflow); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b expected 1 idle %0d", overflow, i); end
    end
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_unf got %b expected 0", underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b0, 1'b1, 16'h0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL unf_flag got %b expected 1", underflow); end
    checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL unf_count got %0d expected 0", count); end
    cycle(1'b1, 1'b0, 16'd7);
    checks++; if (tos !== 16'd7) begin errors++; $display("[TB] FAIL unf_tos got %h expected 0007", tos); end
    checks++; if (count !== 6'd1) begin errors++; $display("[TB] FAIL unf_count1 got %0d expected 1", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL unf_sticky got %b expected 1", underflow); end
  endtask

  task automatic test_combined();
    do_reset();
    cycle(1'b1, 1'b0, 16'd5);
    cycle(1'b1, 1'b0, 16'd9);
    cycle(1'b1, 1'b1, 16'd42);
    checks++; if (count !== 6'd2) begin errors++; $display("[TB] FAIL rep_count got %0d expected 2", count); end
    checks++; if (tos !== 16'd42) begin errors++; $display("[TB] FAIL rep_tos got %0d expected 42", tos); end
    checks++; if (nos !== 16'd5) begin errors++; $display("[TB] FAIL rep_nos got %0d expected 5", nos); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL rep_flags got %b%b expected 00", overflow, underflow); end
    do_reset();
    cycle(1'b1, 1'b1, 16'd3);
    checks++; if (count !== 6'd1) begin errors++; $display("[TB] FAIL pe_count got %0d expected 1", count); end
    checks++; if (tos !== 16'd3) begin errors++; $display("[TB] FAIL pe_tos got %0d expected 3", tos); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL pe_flags got %b%b expected 00", overflow, underflow); end
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 16'(i + 100));
    cycle(1'b1, 1'b1, 16'h1234);
    checks++; if (count !== 6'd32 || tos !== 16'h1234) begin errors++; $display("[TB] FAIL rep_full got count=%0d tos=%h expected count=32 tos=1234", count, tos); end
    checks++; if (nos !== 16'd130) begin errors++; $display("[TB] FAIL rep_full_nos got %0d expected 130", nos); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rep_full_ovf got %b expected 0", overflow); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 16'(i + 1));
    for (int i = 0; i < 28; i++) cycle(1'b0, 1'b1, 16'h0);
    checks++; if (count !== 6'd4 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL prio_setup got count=%0d ovf=%b expected count=4 ovf=1", count, overflow); end
    checks++; if (tos !== 16'd4) begin errors++; $display("[TB] FAIL prio_setup_tos got %0d expected 4", tos); end
    reset = 1'b1;
    cycle(1'b1, 1'b0, 16'hBEEF);
    reset = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL prio_count got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL prio_flags got %b%b expected 00", overflow, underflow); end
    checks++; if (tos !== 16'h0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL prio_tos got tos=%h empty=%b expected tos=0000 empty=1", tos, empty); end
  endtask

  initial begin
    #1;
    test_reset();
    test_push_pop();
    test_full();
    test_underflow();
    test_combined();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
